ccd_pixel_capture: RTL and testbench
====================================

Name: ccd_pixel_capture

Overview:
- Downstream stage of the TCD1209D timing driver, in the same sys_clk domain.
- Uses the driver's pclk and os_tvalid to time sampling of the parallel ADC digitising the CCD OS output.
- Discards leading and trailing dummy pixels and subtracts a programmable black level with floor clamp.
- Delivers active pixels as a ready/valid stream with start-of-line and end-of-line markers, through a 4-deep output FIFO.

Parameters:
- DATA_W, 12: ADC and pixel width in bits.
- LEAD_DUMMY, 32: pixels discarded after os_tvalid rises.
- ACTIVE_PIX, 2048: effective pixels per line.
- SAMPLE_DLY, 6: sys_clk cycles from the pclk falling edge to the adc_data sample point. Legal range 1..14.
- FIFO_DEPTH, 4: output FIFO entries. Must be a power of 2.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- pclk  in  1  driver pixel clock. Registered in the sys_clk domain; 16 sys_clk period.
- os_tvalid  in  1  driver line-valid. Changes only on pclk rising edges.
- adc_data  in  DATA_W  ADC parallel output.
- black_level  in  DATA_W  value subtracted from every active pixel. Quasi-static.
- m_tdata  out  DATA_W  pixel value.
- m_tvalid  out  1  output data valid.
- m_tready  in  1  downstream ready.
- m_tuser  out  1  first active pixel of the line.
- m_tlast  out  1  last active pixel of the line.
- line_cnt  out  16  count of completed lines.
- err_clr  in  1  clears the sticky error flags.
- ovf_err  out  1  sticky: a pixel was dropped because the FIFO was full.
- short_err  out  1  sticky: os_tvalid fell before ACTIVE_PIX pixels were captured.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; all counters 0; FIFO empty; m_tvalid=0, m_tuser=0, m_tlast=0, m_tdata=0, line_cnt=0, ovf_err=0, short_err=0.
- Edge detect:
  - pclk_d is a one-cycle delayed copy of pclk.
  - fall = pclk_d & ~pclk.
  - tv_rise = os_tvalid & ~os_tvalid_d.
- Sample timer: on fall with os_tvalid=1, load dly_cnt=SAMPLE_DLY. It decrements each cycle; at 1 it generates samp (a one-cycle strobe) and adc_data is captured into the pipeline.
- State machine:
  - IDLE: on tv_rise, clear pix_idx to 0 and go to DUMMY.
  - DUMMY: each samp increments pix_idx; nothing is pushed. When pix_idx reaches LEAD_DUMMY, go to ACTIVE with act_idx=0.
  - ACTIVE: each samp pushes one pixel and increments act_idx.
    - The pixel with act_idx=0 carries tuser=1.
    - The pixel with act_idx=ACTIVE_PIX-1 carries tlast=1; that push increments line_cnt (wraps at 16 bits) and moves the state to TAIL.
  - TAIL: ignore samples. Return to IDLE when os_tvalid=0.
  - Any state other than IDLE, when os_tvalid=0 is detected: go to IDLE.
    - If this occurs in DUMMY or ACTIVE (line incomplete), set short_err.
    - No synthetic tlast is emitted.
  - tv_rise while not in IDLE: restart in DUMMY with pix_idx=0, and set short_err if the state was DUMMY or ACTIVE.
- Arithmetic:
  - pixel = adc_data - black_level, computed at DATA_W+1 bits.
  - A negative result saturates to 0. No upper clamp is needed.
  - Sample-to-FIFO-write latency: 1 cycle (a registered subtract).
- FIFO and handshake:
  - A word transfers when m_tvalid & m_tready.
  - m_tdata, m_tuser and m_tlast are stable while m_tvalid=1 and m_tready=0.
  - A push into a full FIFO drops the word and sets ovf_err.
  - A simultaneous push and pop while full is accepted; this is not an overflow.
  - Read latency: m_tvalid rises 1 cycle after the first write into an empty FIFO.
  - Pointers wrap modulo FIFO_DEPTH.
- Errors: err_clr=1 clears ovf_err and short_err. If a new error event occurs in the same cycle as err_clr, the set wins.
- Throughput: at most one pixel per 16 cycles enters, so with m_tready held high overflow is impossible.

Test Plan:
- Nominal line, SAMPLE_DLY=6, black_level=0, adc_data equal to the pixel index, m_tready=1 → expected output:
  - exactly 2048 beats with values 32..2079;
  - tuser on value 32, tlast on value 2079;
  - line_cnt=1;
  - no errors.
- Black-level clamp: black_level=100, adc_data alternating 50 and 500 → outputs alternate 0 and 400.
- Backpressure: m_tready=0 for 100 cycles mid-line → expected:
  - about 6 pixels arrive, so 2 are dropped once the 4 entries are full;
  - ovf_err=1;
  - the surviving 4 words are output in order once ready returns.
  - A later err_clr pulse clears ovf_err.
- Short line: os_tvalid drops after 500 active pixels → expected:
  - 500 beats with no tlast;
  - short_err=1; state returns to IDLE;
  - the next full line is captured correctly with line_cnt=1.
- Reset mid-line: assert rst_n=0 during ACTIVE → expected:
  - outputs go to 0 immediately and the FIFO is empty;
  - after release, capture waits for the next tv_rise, then a clean 2048-pixel line.
- Sample timing: SAMPLE_DLY=1 and 14, adc_data changing every sys_clk → each captured value equals the adc_data present exactly SAMPLE_DLY cycles after the pclk fall.

Source files
------------

// File: rtl/ccd_pixel_capture.sv
// CCD pixel capture: times ADC sampling from the driver's pclk/os_tvalid,
// drops leading dummy pixels, subtracts a black level with floor clamp and
// streams active pixels through a small output FIFO.
module ccd_pixel_capture #(
    parameter int DATA_W     = 12,
    parameter int LEAD_DUMMY = 32,
    parameter int ACTIVE_PIX = 2048,
    parameter int SAMPLE_DLY = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              pclk,
    input  logic              os_tvalid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [DATA_W-1:0] black_level,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tuser,
    output logic              m_tlast,
    output logic [15:0]       line_cnt,
    input  logic              err_clr,
    output logic              ovf_err,
    output logic              short_err
);

    localparam int PIX_W = $clog2(LEAD_DUMMY + 1);
    localparam int ACT_W = (ACTIVE_PIX > 1) ? $clog2(ACTIVE_PIX) : 1;
    localparam int DLY_W = 4;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int WORD_W = DATA_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DUMMY,
        S_ACTIVE,
        S_TAIL
    } state_t;

    state_t             state, state_nxt;
    logic               pclk_d, os_tvalid_d;
    logic               fall, tv_rise, samp;
    logic [DLY_W-1:0]   dly_cnt;
    logic [PIX_W-1:0]   pix_idx, pix_nxt, pix_inc;
    logic [ACT_W-1:0]   act_idx, act_nxt;
    logic               push_nxt, user_nxt, last_nxt, line_inc, short_set;

    logic               pipe_valid, pipe_user, pipe_last;
    logic [DATA_W-1:0]  pipe_data;
    logic [DATA_W:0]    diff;

    logic [WORD_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, pop, wr_en, ovf_set;

    assign fall    = pclk_d & ~pclk;
    assign tv_rise = os_tvalid & ~os_tvalid_d;
    assign samp    = (dly_cnt == DLY_W'(1));
    assign pix_inc = pix_idx + 1'b1;
    assign diff    = {1'b0, adc_data} - {1'b0, black_level};

    // Edge-detect history and the pclk-fall-to-sample delay timer.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_d      <= 1'b0;
            os_tvalid_d <= 1'b0;
            dly_cnt     <= '0;
        end else begin
            pclk_d      <= pclk;
            os_tvalid_d <= os_tvalid;
            if (fall && os_tvalid)
                dly_cnt <= DLY_W'(SAMPLE_DLY);
            else if (dly_cnt != '0)
                dly_cnt <= dly_cnt - 1'b1;
        end
    end

    // Line state and pixel index registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pix_idx <= '0;
            act_idx <= '0;
        end else begin
            state   <= state_nxt;
            pix_idx <= pix_nxt;
            act_idx <= act_nxt;
        end
    end

    // Next-state: a new line start or a dropped os_tvalid overrides sampling.
    always_comb begin
        state_nxt = state;
        pix_nxt   = pix_idx;
        act_nxt   = act_idx;
        push_nxt  = 1'b0;
        user_nxt  = 1'b0;
        last_nxt  = 1'b0;
        line_inc  = 1'b0;
        short_set = 1'b0;
        if (tv_rise) begin
            state_nxt = S_DUMMY;
            pix_nxt   = '0;
            short_set = (state == S_DUMMY) || (state == S_ACTIVE);
        end else if (state != S_IDLE && !os_tvalid) begin
            state_nxt = S_IDLE;
            short_set = (state == S_DUMMY) || (state == S_ACTIVE);
        end else begin
            case (state)
                S_DUMMY: begin
                    if (samp) begin
                        pix_nxt = pix_inc;
                        if (pix_inc == PIX_W'(LEAD_DUMMY)) begin
                            state_nxt = S_ACTIVE;
                            act_nxt   = '0;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (samp) begin
                        push_nxt = 1'b1;
                        user_nxt = (act_idx == '0);
                        if (act_idx == ACT_W'(ACTIVE_PIX - 1)) begin
                            last_nxt  = 1'b1;
                            line_inc  = 1'b1;
                            state_nxt = S_TAIL;
                        end else begin
                            act_nxt = act_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered black-level subtract; a borrow out means negative, clamp to 0.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= 1'b0;
            pipe_user  <= 1'b0;
            pipe_last  <= 1'b0;
            pipe_data  <= '0;
        end else begin
            pipe_valid <= push_nxt;
            if (push_nxt) begin
                pipe_user <= user_nxt;
                pipe_last <= last_nxt;
                pipe_data <= diff[DATA_W] ? '0 : diff[DATA_W-1:0];
            end
        end
    end

    assign m_tvalid = (count != '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign pop      = m_tvalid & m_tready;
    assign wr_en    = pipe_valid & (~full | pop);
    assign ovf_set  = pipe_valid & full & ~pop;
    assign {m_tuser, m_tlast, m_tdata} = mem[rd_ptr];

    // Output FIFO storage and pointers; a pop frees the slot for a same-cycle push.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {pipe_user, pipe_last, pipe_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Line counter and sticky error flags; a same-cycle set beats err_clr.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt  <= '0;
            ovf_err   <= 1'b0;
            short_err <= 1'b0;
        end else begin
            if (line_inc)
                line_cnt <= line_cnt + 16'd1;
            if (err_clr) begin
                ovf_err   <= 1'b0;
                short_err <= 1'b0;
            end
            if (ovf_set)
                ovf_err <= 1'b1;
            if (short_set)
                short_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ccd_pixel_capture.sv
// Bench for ccd_pixel_capture: three instances (sample delays 6, 1, 14) share
// one stimulus; each is scored against a line-timing/queue reference model.
`timescale 1ns/1ps
module tb_ccd_pixel_capture;

    localparam int DW     = 12;
    localparam int LEAD   = 32;
    localparam int DEPTH  = 4;
    localparam int NI     = 3;
    localparam int M_INDEX = 0;
    localparam int M_ALT   = 1;
    localparam int M_RAND  = 2;

    function automatic int sd_of(input int i);
        return (i == 0) ? 6 : ((i == 1) ? 1 : 14);
    endfunction

    function automatic int ap_of(input int i);
        return (i == 0) ? 2048 : 64;
    endfunction

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } pix_t;

    logic          sys_clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          pclk = 1'b1;
    logic          os_tvalid = 1'b0;
    logic          m_tready = 1'b1;
    logic          err_clr = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic [DW-1:0] black_level = '0;

    logic [DW-1:0] m_tdata  [NI];
    logic          m_tvalid [NI];
    logic          m_tuser  [NI];
    logic          m_tlast  [NI];
    logic          ovf_err  [NI];
    logic          short_err[NI];
    logic [15:0]   line_cnt [NI];

    always #5 sys_clk = ~sys_clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ccd_pixel_capture #(
            .DATA_W    (DW),
            .LEAD_DUMMY(LEAD),
            .ACTIVE_PIX(ap_of(g)),
            .SAMPLE_DLY(sd_of(g)),
            .FIFO_DEPTH(DEPTH)
        ) u_dut (
            .sys_clk    (sys_clk),
            .rst_n      (rst_n),
            .pclk       (pclk),
            .os_tvalid  (os_tvalid),
            .adc_data   (adc_data),
            .black_level(black_level),
            .m_tdata    (m_tdata[g]),
            .m_tvalid   (m_tvalid[g]),
            .m_tready   (m_tready),
            .m_tuser    (m_tuser[g]),
            .m_tlast    (m_tlast[g]),
            .line_cnt   (line_cnt[g]),
            .err_clr    (err_clr),
            .ovf_err    (ovf_err[g]),
            .short_err  (short_err[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cur_i = 0;

    // Reference model state
    pix_t        mq      [NI][$];
    pix_t        pend    [NI];
    bit          pend_v  [NI];
    logic [15:0] e_lines [NI];
    bit          e_ovf   [NI];
    bit          e_short [NI];
    bit          line_done[NI];
    int unsigned dut_beats[NI];

    // Line schedule
    int cyc = 0;
    bit ln_on = 0;
    int ln_start = 0;
    int ln_len = 0;
    int ln_mode = M_RAND;
    bit rdy_req = 1;
    bit clr_req = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (t=%0t)", tag, cur_i, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] gen_adc(input int c);
        int d = c - ln_start - 8;
        if (ln_on && ln_mode == M_INDEX)
            return (d < 0) ? '0 : DW'(d / 16);
        if (ln_on && ln_mode == M_ALT)
            return (d < 0 || (d / 16) % 2 == 0) ? 12'd50 : 12'd500;
        return DW'($urandom);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            pend_v[i]    = 0;
            e_lines[i]   = '0;
            e_ovf[i]     = 0;
            e_short[i]   = 0;
            line_done[i] = 1;
        end
    endtask

    // Advance the model over the current cycle (inputs already driven).
    task automatic model_update();
        for (int i = 0; i < NI; i++) begin
            bit pop = m_tready && (mq[i].size() > 0);
            bit set_ovf = 0;
            bit set_short = 0;
            int d;
            if (pop)
                void'(mq[i].pop_front());
            if (pend_v[i]) begin
                if (mq[i].size() == DEPTH) set_ovf = 1;
                else mq[i].push_back(pend[i]);
            end
            pend_v[i] = 0;
            if (ln_on && cyc == ln_start)
                line_done[i] = 0;
            d = cyc - ln_start - 8 - sd_of(i);
            if (ln_on && os_tvalid && d >= 0 && d % 16 == 0) begin
                int k = d / 16;
                if (k >= LEAD && k < LEAD + ap_of(i)) begin
                    pend[i].d = (adc_data >= black_level) ? adc_data - black_level : '0;
                    pend[i].u = (k == LEAD);
                    pend[i].l = (k == LEAD + ap_of(i) - 1);
                    pend_v[i] = 1;
                    if (pend[i].l) begin
                        e_lines[i]   = e_lines[i] + 16'd1;
                        line_done[i] = 1;
                    end
                end
            end
            if (ln_on && cyc == ln_start + 16 * ln_len && !line_done[i])
                set_short = 1;
            if (err_clr) begin
                e_ovf[i]   = 0;
                e_short[i] = 0;
            end
            if (set_ovf)   e_ovf[i] = 1;
            if (set_short) e_short[i] = 1;
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            cur_i = i;
            check("tvalid", 32'(m_tvalid[i]), 32'(mq[i].size() > 0));
            if (mq[i].size() > 0) begin
                check("tdata", 32'(m_tdata[i]), 32'(mq[i][0].d));
                check("tuser", 32'(m_tuser[i]), 32'(mq[i][0].u));
                check("tlast", 32'(m_tlast[i]), 32'(mq[i][0].l));
            end
            check("line_cnt", 32'(line_cnt[i]), 32'(e_lines[i]));
            check("ovf_err", 32'(ovf_err[i]), 32'(e_ovf[i]));
            check("short_err", 32'(short_err[i]), 32'(e_short[i]));
        end
        cyc++;
        pclk      = (cyc % 16) < 8;
        os_tvalid = ln_on && cyc >= ln_start && cyc < ln_start + 16 * ln_len;
        adc_data  = gen_adc(cyc);
        m_tready  = rdy_req;
        err_clr   = clr_req;
        for (int i = 0; i < NI; i++) begin
            cur_i = i;
            if (m_tvalid[i] && m_tready) begin
                dut_beats[i]++;
                if (ln_mode == M_INDEX && m_tuser[i])
                    check("first_pix", 32'(m_tdata[i]), 32'(LEAD));
                if (ln_mode == M_INDEX && m_tlast[i])
                    check("last_pix", 32'(m_tdata[i]), 32'(LEAD + ap_of(i) - 1));
            end
        end
        model_update();
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    // Line starts on a pclk rising edge (phase 0 of the 16-cycle period).
    task automatic start_line(input int len, input int mode);
        while ((cyc + 1) % 16 != 0) step();
        ln_start = cyc + 1;
        ln_len   = len;
        ln_mode  = mode;
        ln_on    = 1;
        for (int i = 0; i < NI; i++) dut_beats[i] = 0;
    endtask

    task automatic line(input int len, input int mode, input int gap);
        start_line(len, mode);
        steps(16 * len + gap);
    endtask

    task automatic pulse_clr();
        clr_req = 1;
        step();
        clr_req = 0;
        steps(2);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            cur_i = i;
            check({tag, "_tvalid"}, 32'(m_tvalid[i]), 32'd0);
            check({tag, "_tdata"},  32'(m_tdata[i]),  32'd0);
            check({tag, "_tuser"},  32'(m_tuser[i]),  32'd0);
            check({tag, "_tlast"},  32'(m_tlast[i]),  32'd0);
            check({tag, "_lines"},  32'(line_cnt[i]), 32'd0);
            check({tag, "_ovf"},    32'(ovf_err[i]),  32'd0);
            check({tag, "_short"},  32'(short_err[i]), 32'd0);
        end
    endtask

    initial begin
        model_clear();
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst");
        steps(4);
        #2 rst_n = 1'b1;
        steps(20);

        // Black-level clamp: 50/500 against 100 gives 0/400
        black_level = 12'd100;
        line(120, M_ALT, 64);
        pulse_clr();

        // Backpressure mid-line forces FIFO overflow
        black_level = DW'($urandom_range(0, 300));
        start_line(140, M_RAND);
        steps(16 * 60);
        rdy_req = 0;
        steps(100);
        for (int i = 0; i < NI; i++) begin
            cur_i = i;
            check("bp_ovf", 32'(ovf_err[i]), 32'd1);
        end
        rdy_req = 1;
        steps(16 * 80 + 64);
        pulse_clr();
        for (int i = 0; i < NI; i++) begin
            cur_i = i;
            check("clr_ovf", 32'(ovf_err[i]), 32'd0);
        end

        // Short line: only 500 active pixels reach the first instance
        black_level = '0;
        line(532, M_RAND, 64);
        cur_i = 0;
        check("short_beats", 32'(dut_beats[0]), 32'd500);
        check("short_flag", 32'(short_err[0]), 32'd1);
        pulse_clr();

        // Asynchronous reset in the middle of an active line
        start_line(140, M_RAND);
        steps(16 * 50);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        model_clear();
        ln_on = 0;
        steps(40);
        #2 rst_n = 1'b1;
        steps(40);

        // Clean nominal line after reset
        black_level = '0;
        line(LEAD + 2048 + 2, M_INDEX, 64);
        for (int i = 0; i < NI; i++) begin
            cur_i = i;
            check("nom_beats", 32'(dut_beats[i]), 32'(ap_of(i)));
            check("nom_lines", 32'(line_cnt[i]), 32'd1);
            check("nom_ovf", 32'(ovf_err[i]), 32'd0);
            check("nom_short", 32'(short_err[i]), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
